conv_job_sequencer: RTL and testbench

//  Runs a batch of 3x3 XNOR-popcount convolution jobs on the single conv engine, one job at a time.
//  For each job it presents that job's kernel word address, input matrix base and output base to the engine.
//  It then pulses the engine's run input and tracks the engine's busy signal until the job completes.

---
 rtl/conv_job_sequencer.sv | 129 ++++++++++++
 tb/tb_conv_job_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_job_sequencer.sv
// Batch sequencer for the 3x3 XNOR-popcount conv engine: launches one job at a time,
// steps the address bases between jobs and supervises the engine run/busy handshake.
module conv_job_sequencer #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned IN_STRIDE  = 32,
    parameter int unsigned OUT_STRIDE = 32,
    parameter int unsigned ACK_TMO    = 16,
    parameter int unsigned RUN_TMO    = 1024
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              seq_start,
    input  logic [CNT_W-1:0]  seq_job_count,
    input  logic [ADDR_W-1:0] seq_in_base,
    input  logic [ADDR_W-1:0] seq_out_base,
    input  logic [ADDR_W-1:0] seq_wmem_base,
    output logic              seq_busy,
    output logic              seq_done,
    output logic              seq_error,
    output logic [CNT_W-1:0]  seq_jobs_done,
    output logic              eng_run,
    input  logic              eng_busy,
    output logic [ADDR_W-1:0] eng_in_base,
    output logic [ADDR_W-1:0] eng_out_base,
    output logic [ADDR_W-1:0] eng_wmem_addr
);

    localparam int unsigned TMR_MAX = (ACK_TMO > RUN_TMO) ? ACK_TMO : RUN_TMO;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_NEXT,
        S_FINISH
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   job_count;
    logic [TMR_W-1:0]   timer;
    logic [TMR_W-1:0]   timer_inc;
    logic [CNT_W-1:0]   jobs_inc;

    assign timer_inc = timer + TMR_W'(1);
    assign jobs_inc  = seq_jobs_done + CNT_W'(1);

    // Sequencer FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state         <= S_IDLE;
            job_count     <= '0;
            timer         <= '0;
            seq_busy      <= 1'b0;
            seq_done      <= 1'b0;
            seq_error     <= 1'b0;
            seq_jobs_done <= '0;
            eng_run       <= 1'b0;
            eng_in_base   <= '0;
            eng_out_base  <= '0;
            eng_wmem_addr <= '0;
        end else begin
            eng_run  <= 1'b0;
            seq_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    seq_busy <= 1'b0;
                    // A start coinciding with the done pulse belongs to the old batch and is dropped.
                    if (seq_start && !seq_done) begin
                        seq_busy      <= 1'b1;
                        job_count     <= seq_job_count;
                        eng_in_base   <= seq_in_base;
                        eng_out_base  <= seq_out_base;
                        eng_wmem_addr <= seq_wmem_base;
                        seq_error     <= 1'b0;
                        seq_jobs_done <= '0;
                        timer         <= '0;
                        state         <= (seq_job_count == '0) ? S_FINISH : S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    eng_run <= 1'b1;
                    state   <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (eng_busy) begin
                        timer <= '0;
                        state <= S_WAIT_DONE;
                    end else if (timer_inc == TMR_W'(ACK_TMO)) begin
                        seq_error <= 1'b1;
                        state     <= S_FINISH;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                S_WAIT_DONE: begin
                    if (!eng_busy) begin
                        timer <= '0;
                        state <= S_NEXT;
                    end else if (timer_inc == TMR_W'(RUN_TMO)) begin
                        seq_error <= 1'b1;
                        state     <= S_FINISH;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                S_NEXT: begin
                    seq_jobs_done <= jobs_inc;
                    if (jobs_inc == job_count) begin
                        state <= S_FINISH;
                    end else begin
                        eng_in_base   <= eng_in_base + ADDR_W'(IN_STRIDE);
                        eng_out_base  <= eng_out_base + ADDR_W'(OUT_STRIDE);
                        eng_wmem_addr <= eng_wmem_addr + ADDR_W'(1);
                        state         <= S_LAUNCH;
                    end
                end
                S_FINISH: begin
                    seq_done <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_job_sequencer.sv
// Scoreboard bench for conv_job_sequencer: a behavioural engine model, expected launches
// and batch results queued at start, and a monitor that checks them as the DUT reports them.
module tb_conv_job_sequencer;

    localparam int unsigned ADDR_W     = 12;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned IN_STRIDE  = 32;
    localparam int unsigned OUT_STRIDE = 32;
    localparam int unsigned ACK_TMO    = 16;
    localparam int unsigned RUN_TMO    = 1024;

    localparam int MODE_NORMAL = 0;
    localparam int MODE_NEVER  = 1;
    localparam int MODE_STUCK  = 2;

    logic              clk;
    logic              reset_b;
    logic              seq_start;
    logic [CNT_W-1:0]  seq_job_count;
    logic [ADDR_W-1:0] seq_in_base;
    logic [ADDR_W-1:0] seq_out_base;
    logic [ADDR_W-1:0] seq_wmem_base;
    logic              seq_busy;
    logic              seq_done;
    logic              seq_error;
    logic [CNT_W-1:0]  seq_jobs_done;
    logic              eng_run;
    logic              eng_busy;
    logic [ADDR_W-1:0] eng_in_base;
    logic [ADDR_W-1:0] eng_out_base;
    logic [ADDR_W-1:0] eng_wmem_addr;

    conv_job_sequencer dut (
        .clk           (clk),
        .reset_b       (reset_b),
        .seq_start     (seq_start),
        .seq_job_count (seq_job_count),
        .seq_in_base   (seq_in_base),
        .seq_out_base  (seq_out_base),
        .seq_wmem_base (seq_wmem_base),
        .seq_busy      (seq_busy),
        .seq_done      (seq_done),
        .seq_error     (seq_error),
        .seq_jobs_done (seq_jobs_done),
        .eng_run       (eng_run),
        .eng_busy      (eng_busy),
        .eng_in_base   (eng_in_base),
        .eng_out_base  (eng_out_base),
        .eng_wmem_addr (eng_wmem_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int run_seen  = 0;
    int done_seen = 0;

    logic [3*ADDR_W-1:0] exp_run[$];
    logic [CNT_W:0]      exp_done[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Engine model: busy rises eng_dly negedges after the run pulse is seen, then lasts eng_len cycles.
    int eng_mode = MODE_NORMAL;
    int eng_dly  = 1;
    int eng_len  = 20;
    int dly_cnt  = 0;
    int hold_cnt = 0;
    bit pending  = 1'b0;

    initial eng_busy = 1'b0;

    always @(negedge clk) begin
        if (!reset_b) begin
            eng_busy = 1'b0;
            pending  = 1'b0;
        end else begin
            if (eng_run && eng_mode != MODE_NEVER) begin
                pending = 1'b1;
                dly_cnt = eng_dly;
            end
            if (pending) begin
                if (dly_cnt == 0) begin
                    eng_busy = 1'b1;
                    hold_cnt = eng_len;
                    pending  = 1'b0;
                end else begin
                    dly_cnt--;
                end
            end else if (eng_busy && eng_mode != MODE_STUCK) begin
                hold_cnt--;
                if (hold_cnt <= 0) eng_busy = 1'b0;
            end
        end
    end

    // Monitor: every run pulse and every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_b) begin
            if (eng_run) begin
                run_seen++;
                chk("run_expected", 64'(exp_run.size() > 0), 64'd1);
                if (exp_run.size() > 0)
                    chk("run_addrs", 64'({eng_in_base, eng_out_base, eng_wmem_addr}),
                        64'(exp_run.pop_front()));
            end
            if (seq_done) begin
                done_seen++;
                chk("done_expected", 64'(exp_done.size() > 0), 64'd1);
                if (exp_done.size() > 0)
                    chk("done_result", 64'({seq_jobs_done, seq_error}), 64'(exp_done.pop_front()));
            end
        end
    end

    // Reference model: job i uses each base advanced by i strides, modulo the address width.
    task automatic push_expected(input int cnt, input int in_b, input int out_b,
                                 input int wm_b, input int mode);
        int n_runs;
        logic [ADDR_W-1:0] a_in, a_out, a_wm;
        n_runs = (mode == MODE_NORMAL) ? cnt : ((cnt == 0) ? 0 : 1);
        for (int i = 0; i < n_runs; i++) begin
            a_in  = ADDR_W'(in_b + i * IN_STRIDE);
            a_out = ADDR_W'(out_b + i * OUT_STRIDE);
            a_wm  = ADDR_W'(wm_b + i);
            exp_run.push_back({a_in, a_out, a_wm});
        end
        if (mode == MODE_NORMAL || cnt == 0)
            exp_done.push_back({CNT_W'(cnt), 1'b0});
        else
            exp_done.push_back({CNT_W'(0), 1'b1});
    endtask

    // Issue a start and check first-response latency: eng_run (or seq_done for count 0) two edges later.
    task automatic launch(input int cnt, input int in_b, input int out_b, input int wm_b, input int mode);
        push_expected(cnt, in_b, out_b, wm_b, mode);
        @(negedge clk);
        seq_job_count = CNT_W'(cnt);
        seq_in_base   = ADDR_W'(in_b);
        seq_out_base  = ADDR_W'(out_b);
        seq_wmem_base = ADDR_W'(wm_b);
        seq_start     = 1'b1;
        @(negedge clk);
        seq_start = 1'b0;
        chk("busy_after_start", 64'(seq_busy), 64'd1);
        @(negedge clk);
        if (cnt == 0) begin
            chk("zero_count_done_latency", 64'(seq_done), 64'd1);
            chk("zero_count_no_run", 64'(eng_run), 64'd0);
        end else begin
            chk("run_latency", 64'(eng_run), 64'd1);
        end
    endtask

    // Wait for seq_done, optionally pulsing stray starts; cycles counts negedges after the latency check.
    task automatic wait_done(input int budget, input bit strays, input bit start_at_done, output int cycles);
        cycles = 0;
        while (!seq_done && cycles < budget) begin
            seq_start = 1'b0;
            if (strays && seq_busy && ($urandom_range(0, 5) == 0)) begin
                seq_job_count = CNT_W'($urandom_range(0, 15));
                seq_in_base   = ADDR_W'($urandom);
                seq_out_base  = ADDR_W'($urandom);
                seq_wmem_base = ADDR_W'($urandom);
                seq_start     = 1'b1;
            end
            @(negedge clk);
            cycles++;
        end
        seq_start = 1'b0;
        if (!seq_done) chk("done_within_budget", 64'(seq_done), 64'd1);
        if (start_at_done) begin
            seq_job_count = CNT_W'(0);
            seq_start     = 1'b1;
        end
        @(negedge clk);
        seq_start = 1'b0;
        chk("busy_cleared_after_done", 64'(seq_busy), 64'd0);
        chk("run_queue_drained", 64'(exp_run.size()), 64'd0);
        chk("done_queue_drained", 64'(exp_done.size()), 64'd0);
        @(negedge clk);
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({seq_busy, seq_done, seq_error, seq_jobs_done, eng_run,
                    eng_in_base, eng_out_base, eng_wmem_addr});
    endfunction

    initial begin
        int cyc;
        int r0;
        int d0;
        int cnt;
        bit saw_done;

        reset_b       = 1'b0;
        seq_start     = 1'b0;
        seq_job_count = '0;
        seq_in_base   = '0;
        seq_out_base  = '0;
        seq_wmem_base = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outputs(), 64'd0);
        reset_b = 1'b1;
        repeat (2) @(negedge clk);

        // Three well-behaved jobs from in=0x000, out=0x100, wmem=1.
        eng_mode = MODE_NORMAL; eng_dly = 1; eng_len = 20;
        launch(3, 'h000, 'h100, 1, MODE_NORMAL);
        wait_done(300, 1'b0, 1'b0, cyc);
        chk("t1_jobs_done_hold", 64'(seq_jobs_done), 64'd3);
        chk("t1_error_clear", 64'(seq_error), 64'd0);

        // Empty batch.
        launch(0, 'h123, 'h456, 7, MODE_NORMAL);
        wait_done(10, 1'b0, 1'b0, cyc);
        chk("t2_jobs_done", 64'(seq_jobs_done), 64'd0);

        // Engine never acknowledges: ACK_TMO low samples, then the FINISH cycle.
        eng_mode = MODE_NEVER;
        r0 = run_seen;
        launch(2, 'h010, 'h020, 3, MODE_NEVER);
        wait_done(100, 1'b0, 1'b0, cyc);
        chk("t3_ack_timeout_latency", 64'(cyc), 64'(ACK_TMO + 1));
        chk("t3_error", 64'(seq_error), 64'd1);
        chk("t3_single_run", 64'(run_seen - r0), 64'd1);

        // Engine busy never drops: 1+dly cycles to be seen, RUN_TMO samples high, then FINISH.
        eng_mode = MODE_STUCK; eng_dly = 1;
        launch(2, 'h200, 'h300, 9, MODE_STUCK);
        wait_done(1200, 1'b0, 1'b0, cyc);
        chk("t4_run_timeout_latency", 64'(cyc), 64'(RUN_TMO + 2 + eng_dly));
        chk("t4_error", 64'(seq_error), 64'd1);
        @(negedge clk);
        eng_mode = MODE_NORMAL;
        reset_b = 1'b0;
        @(negedge clk);
        reset_b = 1'b1;
        @(negedge clk);

        // Output base wraps; stray starts during the batch and one start with seq_done are ignored.
        eng_mode = MODE_NORMAL; eng_dly = 1; eng_len = 20;
        launch(2, 'h040, 'hFF0, 'hFFF, MODE_NORMAL);
        wait_done(300, 1'b1, 1'b1, cyc);
        chk("t5_error_clear_on_start", 64'(seq_error), 64'd0);
        chk("t5_start_with_done_ignored", 64'(seq_done), 64'd0);

        // Reset during the second job's WAIT_DONE aborts with no done pulse.
        r0 = run_seen;
        launch(3, 'h100, 'h200, 5, MODE_NORMAL);
        cyc = 0;
        while (run_seen < r0 + 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("t6_second_run_seen", 64'(run_seen - r0), 64'd2);
        repeat (5) @(negedge clk);
        #2 reset_b = 1'b0;
        #1 chk("t6_async_reset_outputs", all_outputs(), 64'd0);
        exp_run.delete();
        exp_done.delete();
        d0 = done_seen;
        saw_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            saw_done = saw_done | seq_done;
        end
        #2 reset_b = 1'b1;
        repeat (3) begin
            @(negedge clk);
            saw_done = saw_done | seq_done;
        end
        chk("t6_no_done_after_abort", 64'({saw_done, 8'(done_seen - d0)}), 64'd0);
        launch(1, 'h0AB, 'h0CD, 2, MODE_NORMAL);
        wait_done(200, 1'b0, 1'b0, cyc);
        chk("t6_recovery_jobs_done", 64'(seq_jobs_done), 64'd1);

        // Randomized batches with varied engine timing and stray starts.
        for (int it = 0; it < 20; it++) begin
            cnt     = $urandom_range(0, 6);
            eng_dly = $urandom_range(0, 3);
            eng_len = $urandom_range(1, 25);
            launch(cnt, $urandom_range(0, 4095), $urandom_range(0, 4095),
                   $urandom_range(0, 4095), MODE_NORMAL);
            wait_done(cnt * (eng_len + eng_dly + 8) + 20, 1'b1, 1'b0, cyc);
            chk("rand_jobs_done", 64'(seq_jobs_done), 64'(cnt));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
